// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed byte stream into 32-bit writes to the instruction RAM
// and holds the core in reset while a load is in progress.
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle, StLen0, StLen1, StData, StWrite, StDone, StErr
  } state_e;

  localparam logic [15:0] DepthW = 16'(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              in_ready_q, we_q, cpu_hold_q, done_q, err_q;
  logic              xfer;
  logic [15:0]       len_full;
  logic [15:0]       idx_inc;

  assign xfer     = in_valid & in_ready_q;
  assign len_full = {in_data, cnt_q[7:0]};
  assign idx_inc  = idx_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen0;
          idx_d   = 16'd0;
          lane_d  = 2'd0;
        end
      end
      StLen0: begin
        if (xfer) begin
          cnt_d[7:0] = in_data;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (xfer) begin
          cnt_d[15:8] = in_data;
          idx_d       = 16'd0;
          lane_d      = 2'd0;
          if (len_full == 16'd0)     state_d = StDone;
          else if (len_full > DepthW) state_d = StErr;
          else                        state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          wdata_d[8*lane_q +: 8] = in_data;
          lane_d                 = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            state_d = StWrite;
            waddr_d = idx_q[ADDR_W-1:0];
          end
        end
      end
      StWrite: begin
        idx_d   = idx_inc;
        lane_d  = 2'd0;
        state_d = (idx_inc == cnt_q) ? StDone : StData;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output flops are loaded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      in_ready_q <= (state_d == StLen0) || (state_d == StLen1) || (state_d == StData);
      we_q       <= (state_d == StWrite);
      cpu_hold_q <= (state_d != StIdle) && (state_d != StDone);
      done_q     <= (state_d == StDone);
      err_q      <= (state_d == StErr);
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives and samples on the falling edge, models the RAM write port.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, we, cpu_hold, done, err;
  logic [5:0]  waddr;
  logic [31:0] wdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [64];
  int          we_count = 0;
  logic [5:0]  last_waddr = '0;

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      mem[waddr] = wdata;
      we_count++;
      last_waddr = waddr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic clear_mon();
    we_count = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  // Holds the byte until the loader is ready; returns on the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) begin in_valid = 1'b0; @(negedge clk); end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      if (in_ready === 1'b1) begin ok = 1; @(negedge clk); break; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_byte_timeout byte=%h in_ready=%b", b, in_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL rst_we got=%b exp=0", we); end
    vectors++; if (waddr !== 6'd0) begin miscompares++; $display("FAIL rst_waddr got=%h exp=0", waddr); end
    vectors++; if (wdata !== 32'd0) begin miscompares++; $display("FAIL rst_wdata got=%h exp=0", wdata); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_hold got=%b exp=0", cpu_hold); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%b exp=0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b exp=0", err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_word();
    clear_mon();
    pulse_start();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL start_in_ready got=%b exp=1", in_ready); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL start_cpu_hold got=%b exp=1", cpu_hold); end
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00100513, 0);
    vectors++; if (we !== 1'b1 || waddr !== 6'd0 || wdata !== 32'h00100513)
      begin miscompares++; $display("FAIL w0 got we=%b a=%h d=%h exp we=1 a=00 d=00100513", we, waddr, wdata); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL w0_in_ready got=%b exp=0", in_ready); end
    send_word(32'h00200593, 0);
    vectors++; if (we !== 1'b1 || waddr !== 6'd1 || wdata !== 32'h00200593)
      begin miscompares++; $display("FAIL w1 got we=%b a=%h d=%h exp we=1 a=01 d=00200593", we, waddr, wdata); end
    @(negedge clk);
    vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0 || we !== 1'b0)
      begin miscompares++; $display("FAIL two_done got done=%b hold=%b we=%b exp 1 0 0", done, cpu_hold, we); end
    vectors++; if (we_count !== 2) begin miscompares++; $display("FAIL two_count got=%0d exp=2", we_count); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    pulse_start();
    send_byte(8'h02, $urandom_range(0, 3)); send_byte(8'h00, $urandom_range(0, 3));
    send_word(32'h00100513, 3);
    send_word(32'h00200593, 3);
    repeat (3) @(negedge clk);
    vectors++; if (mem[0] !== 32'h00100513) begin miscompares++; $display("FAIL bp_mem0 got=%h exp=00100513", mem[0]); end
    vectors++; if (mem[1] !== 32'h00200593) begin miscompares++; $display("FAIL bp_mem1 got=%h exp=00200593", mem[1]); end
    vectors++; if (we_count !== 2) begin miscompares++; $display("FAIL bp_count got=%0d exp=2", we_count); end
    vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin miscompares++; $display("FAIL bp_done got done=%b hold=%b exp 1 0", done, cpu_hold); end
  endtask

  task automatic test_n0();
    clear_mon();
    pulse_start();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL n0_done_clear got=%b exp=0", done); end
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin miscompares++; $display("FAIL n0_done got done=%b hold=%b exp 1 0", done, cpu_hold); end
    repeat (2) @(negedge clk);
    vectors++; if (we_count !== 0) begin miscompares++; $display("FAIL n0_count got=%0d exp=0", we_count); end
  endtask

  task automatic test_n64();
    clear_mon();
    pulse_start();
    send_byte(8'h40, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 64; i++) send_word(32'hC000_0000 | 32'(i), 1);
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL n64_done got=%b exp=1", done); end
    vectors++; if (we_count !== 64) begin miscompares++; $display("FAIL n64_count got=%0d exp=64", we_count); end
    vectors++; if (last_waddr !== 6'd63) begin miscompares++; $display("FAIL n64_last_addr got=%0d exp=63", last_waddr); end
    vectors++; if (mem[63] !== 32'hC000003F) begin miscompares++; $display("FAIL n64_mem63 got=%h exp=c000003f", mem[63]); end
    vectors++; if (mem[0] !== 32'hC0000000) begin miscompares++; $display("FAIL n64_mem0 got=%h exp=c0000000", mem[0]); end
  endtask

  task automatic test_n65();
    clear_mon();
    pulse_start();
    send_byte(8'h41, 0); send_byte(8'h00, 0);
    vectors++; if (err !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0)
      begin miscompares++; $display("FAIL n65_err got err=%b hold=%b rdy=%b done=%b exp 1 1 0 0", err, cpu_hold, in_ready, done); end
    in_valid = 1'b1; in_data = 8'h13;
    repeat (6) @(negedge clk);
    vectors++; if (in_ready !== 1'b0 || err !== 1'b1) begin miscompares++; $display("FAIL n65_stall got rdy=%b err=%b exp 0 1", in_ready, err); end
    in_valid = 1'b0;
    vectors++; if (we_count !== 0) begin miscompares++; $display("FAIL n65_count got=%0d exp=0", we_count); end
  endtask

  task automatic test_restart_from_err();
    clear_mon();
    pulse_start();
    vectors++; if (err !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1)
      begin miscompares++; $display("FAIL rs_clear got err=%b done=%b rdy=%b exp 0 0 1", err, done, in_ready); end
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(32'hDEADBEEF, 0);
    vectors++; if (we !== 1'b1 || waddr !== 6'd0 || wdata !== 32'hDEADBEEF)
      begin miscompares++; $display("FAIL rs_write got we=%b a=%h d=%h exp we=1 a=00 d=deadbeef", we, waddr, wdata); end
    @(negedge clk);
    vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0 || we_count !== 1)
      begin miscompares++; $display("FAIL rs_done got done=%b hold=%b cnt=%0d exp 1 0 1", done, cpu_hold, we_count); end
  endtask

  task automatic test_start_in_data();
    clear_mon();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    pulse_start();
    vectors++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin miscompares++; $display("FAIL sid_state got rdy=%b hold=%b exp 1 1", in_ready, cpu_hold); end
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    vectors++; if (we !== 1'b1 || waddr !== 6'd0 || wdata !== 32'h44332211)
      begin miscompares++; $display("FAIL sid_write got we=%b a=%h d=%h exp we=1 a=00 d=44332211", we, waddr, wdata); end
    @(negedge clk);
    vectors++; if (done !== 1'b1 || we_count !== 1) begin miscompares++; $display("FAIL sid_done got done=%b cnt=%0d exp 1 1", done, we_count); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00100513, 0);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0 || we !== 1'b0 || waddr !== 6'd0 || wdata !== 32'd0 ||
                   cpu_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      begin miscompares++; $display("FAIL rm_outputs got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b exp all 0",
                                    in_ready, we, waddr, wdata, cpu_hold, done, err); end
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h93;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    vectors++; if (we_count !== 1 || in_ready !== 1'b0 || cpu_hold !== 1'b0)
      begin miscompares++; $display("FAIL rm_after got cnt=%0d rdy=%b hold=%b exp 1 0 0", we_count, in_ready, cpu_hold); end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_backpressure();
    test_n0();
    test_n64();
    test_n65();
    test_restart_from_err();
    test_start_in_data();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
